// File: rtl/cpu_control_fsm_if.sv
// Handshake and register-file control bundle between the instruction sequencer
// and the datapath that issues instructions to it.
interface cpu_control_fsm_if #(
  parameter int IW = 10,
  parameter int AW = 2
);
  logic          EXECUTE;
  logic [IW-1:0] INSTR;
  logic          BUSY;
  logic          DONE;
  logic          ENW;
  logic [AW-1:0] WRA;
  logic          ENR0;
  logic [AW-1:0] RDA0;
  logic          ENR1;
  logic [AW-1:0] RDA1;
  logic [2:0]    ALUOP;
  logic          GIN;
  logic          GOUT;
  logic          EXTRN;

  // master issues instructions; slave is the sequencer
  modport master (
    output EXECUTE, INSTR,
    input  BUSY, DONE, ENW, WRA, ENR0, RDA0, ENR1, RDA1, ALUOP, GIN, GOUT, EXTRN
  );
  modport slave (
    input  EXECUTE, INSTR,
    output BUSY, DONE, ENW, WRA, ENR0, RDA0, ENR1, RDA1, ALUOP, GIN, GOUT, EXTRN
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle sequencer for the 10-bit processor: latches an instruction and
// drives register-file, ALU, G-register and bus-source controls from state+IR.
module cpu_control_fsm #(
  parameter int IW = 10,
  parameter int AW = 2
) (
  input  logic             CLKb,
  input  logic             RSTb,
  cpu_control_fsm_if.slave cif
);
  typedef enum logic [1:0] {IDLE, T1, T2} state_t;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_COPY = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd6;

  state_t        state, nxt;
  logic [IW-1:0] ir;
  logic [AW-1:0] rx, ry;
  logic [3:0]    op;
  logic [3:0]    op_rel;
  logic [2:0]    alu_code;
  logic          is_alu;
  logic          unused_rsvd;

  logic          busy, done, enw, enr0, enr1, gin, gout, extrn;
  logic [AW-1:0] wra, rda0, rda1;
  logic [2:0]    aluop;

  assign rx          = ir[IW-1 -: AW];
  assign ry          = ir[IW-1-AW -: AW];
  assign op          = ir[3:0];
  assign unused_rsvd = ^ir[5:4];

  // ALU opcodes 2..6 map onto ALU function codes 0..4 in order
  assign is_alu   = (op >= OP_ADD) && (op <= OP_OR);
  assign op_rel   = op - OP_ADD;
  assign alu_code = is_alu ? op_rel[2:0] : 3'd0;

  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= nxt;
      if (nxt == T1) ir <= cif.INSTR;
    end
  end

  // Outputs depend on state and IR only, so they hold steady through the
  // falling-edge register-file write regardless of what the inputs do.
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    enw   = 1'b0;
    wra   = '0;
    enr0  = 1'b0;
    rda0  = '0;
    enr1  = 1'b0;
    rda1  = '0;
    aluop = 3'd0;
    gin   = 1'b0;
    gout  = 1'b0;
    extrn = 1'b0;
    unique case (state)
      T1: begin
        busy = 1'b1;
        if (op == OP_LOAD) begin
          extrn = 1'b1;
          enw   = 1'b1;
          wra   = rx;
          done  = 1'b1;
        end else if (op == OP_COPY) begin
          enr0 = 1'b1;
          rda0 = ry;
          enw  = 1'b1;
          wra  = rx;
          done = 1'b1;
        end else if (is_alu) begin
          enr0  = 1'b1;
          rda0  = rx;
          enr1  = 1'b1;
          rda1  = ry;
          aluop = alu_code;
          gin   = 1'b1;
        end else begin
          done = 1'b1;
        end
      end
      T2: begin
        busy  = 1'b1;
        gout  = 1'b1;
        enw   = 1'b1;
        wra   = rx;
        aluop = alu_code;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  // A request is taken in IDLE or on the edge that closes the DONE cycle.
  always_comb begin
    nxt = IDLE;
    if (cif.EXECUTE && ((state == IDLE) || done)) nxt = T1;
    else if ((state == T1) && !done)              nxt = T2;
  end

  assign cif.BUSY  = busy;
  assign cif.DONE  = done;
  assign cif.ENW   = enw;
  assign cif.WRA   = wra;
  assign cif.ENR0  = enr0;
  assign cif.RDA0  = rda0;
  assign cif.ENR1  = enr1;
  assign cif.RDA1  = rda1;
  assign cif.ALUOP = aluop;
  assign cif.GIN   = gin;
  assign cif.GOUT  = gout;
  assign cif.EXTRN = extrn;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench: sequencer driving a behavioural 4x10 register file, ALU and G register,
// checked per cycle and against an instruction-level architectural model.
module tb_cpu_control_fsm;
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       enw;
    logic [1:0] wra;
    logic       enr0;
    logic [1:0] rda0;
    logic       enr1;
    logic [1:0] rda1;
    logic [2:0] aluop;
    logic       gin;
    logic       gout;
    logic       extrn;
  } ctl_t;

  logic CLKb, RSTb;
  cpu_control_fsm_if #(.IW(10), .AW(2)) cif ();

  cpu_control_fsm #(.IW(10), .AW(2)) dut (
    .CLKb (CLKb),
    .RSTb (RSTb),
    .cif  (cif.slave)
  );

  initial CLKb = 1'b0;
  always #5 CLKb = ~CLKb;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0, enw_cnt = 0;
  int exp_done = 0, exp_enw = 0;

  logic [9:0] rf [4];
  logic [9:0] arch [4];
  logic [9:0] g, ext, q0, q1, alu_y, dbus;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural datapath slaved to the sequencer's controls
  always_comb begin
    q0 = cif.ENR0 ? rf[cif.RDA0] : 10'd0;
    q1 = cif.ENR1 ? rf[cif.RDA1] : 10'd0;
    case (cif.ALUOP)
      3'd0:    alu_y = q0 + q1;
      3'd1:    alu_y = q0 - q1;
      3'd2:    alu_y = ~q1;
      3'd3:    alu_y = q0 & q1;
      3'd4:    alu_y = q0 | q1;
      default: alu_y = 10'd0;
    endcase
    dbus = cif.EXTRN ? ext : cif.GOUT ? g : cif.ENR0 ? q0 : 10'd0;
  end

  always @(posedge CLKb) if (cif.GIN) g <= alu_y;
  always @(negedge CLKb) if (cif.ENW) rf[cif.WRA] <= dbus;

  always @(negedge CLKb) begin
    done_cnt += int'(cif.DONE);
    enw_cnt  += int'(cif.ENW);
    chk("bus_excl", 64'($countones({cif.EXTRN, cif.GOUT, cif.ENR0}) <= 1), 64'd1);
  end

  function automatic ctl_t obs_ctl();
    ctl_t c;
    c = '{cif.BUSY, cif.DONE, cif.ENW, cif.WRA, cif.ENR0, cif.RDA0, cif.ENR1,
          cif.RDA1, cif.ALUOP, cif.GIN, cif.GOUT, cif.EXTRN};
    return c;
  endfunction

  function automatic bit is_alu_op(input logic [3:0] op);
    return op inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
  endfunction

  function automatic logic [2:0] alu_fn(input logic [3:0] op);
    case (op)
      4'd2: return 3'b000;
      4'd3: return 3'b001;
      4'd4: return 3'b010;
      4'd5: return 3'b011;
      4'd6: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Expected control word for instruction ins in its ph-th busy cycle
  function automatic ctl_t exp_ctrl(input logic [9:0] ins, input int ph);
    ctl_t e;
    logic [1:0] rx, ry;
    logic [3:0] op;
    rx = ins[9:8];
    ry = ins[7:6];
    op = ins[3:0];
    e = '0;
    e.busy = 1'b1;
    if (ph == 2) begin
      e.gout = 1'b1; e.enw = 1'b1; e.wra = rx; e.done = 1'b1; e.aluop = alu_fn(op);
    end else if (op == 4'd0) begin
      e.extrn = 1'b1; e.enw = 1'b1; e.wra = rx; e.done = 1'b1;
    end else if (op == 4'd1) begin
      e.enr0 = 1'b1; e.rda0 = ry; e.enw = 1'b1; e.wra = rx; e.done = 1'b1;
    end else if (is_alu_op(op)) begin
      e.enr0 = 1'b1; e.rda0 = rx; e.enr1 = 1'b1; e.rda1 = ry;
      e.aluop = alu_fn(op); e.gin = 1'b1;
    end else begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  // Architectural effect of one instruction on the register set
  task automatic arch_exec(input logic [9:0] ins, input logic [9:0] xd);
    logic [1:0] rx, ry;
    rx = ins[9:8];
    ry = ins[7:6];
    case (ins[3:0])
      4'd0: arch[rx] = xd;
      4'd1: arch[rx] = arch[ry];
      4'd2: arch[rx] = arch[rx] + arch[ry];
      4'd3: arch[rx] = arch[rx] - arch[ry];
      4'd4: arch[rx] = ~arch[ry];
      4'd5: arch[rx] = arch[rx] & arch[ry];
      4'd6: arch[rx] = arch[rx] | arch[ry];
      default: ;
    endcase
    exp_done++;
    if (ins[3:0] <= 4'd6) exp_enw++;
  endtask

  // Issue at the next rising edge. keep: EXECUTE stays high (with junk INSTR)
  // through the busy cycles, which must be ignored. chain: leave EXECUTE high
  // so the caller's next issue is taken on the DONE edge.
  task automatic issue(input logic [9:0] ins, input logic [9:0] xd, input bit keep, input bit chain);
    int nph;
    ext     = xd;
    INSTR_d(ins);
    cif.EXECUTE = 1'b1;
    nph = is_alu_op(ins[3:0]) ? 2 : 1;
    for (int p = 1; p <= nph; p++) begin
      @(posedge CLKb); #1;
      cif.INSTR   = 10'($urandom);
      cif.EXECUTE = keep;
      chk($sformatf("ctl_%03h_ph%0d", ins, p), 64'(obs_ctl()), 64'(exp_ctrl(ins, p)));
    end
    if (!chain) cif.EXECUTE = 1'b0;
    arch_exec(ins, xd);
    @(negedge CLKb); #1;
    chk($sformatf("regs_after_%03h", ins), {24'd0, rf[3], rf[2], rf[1], rf[0]},
        {24'd0, arch[3], arch[2], arch[1], arch[0]});
  endtask

  task automatic INSTR_d(input logic [9:0] v);
    cif.INSTR = v;
  endtask

  task automatic idle_chk(input int n);
    cif.EXECUTE = 1'b0;
    repeat (n) begin
      @(posedge CLKb); #1;
      chk("idle", 64'(obs_ctl()), 64'd0);
    end
  endtask

  initial begin
    int d0, w0;
    logic [39:0] snap;
    RSTb = 1'b0;
    cif.EXECUTE = 1'b1;
    cif.INSTR = 10'h200;
    ext = 10'd0;
    g = 10'd0;
    for (int i = 0; i < 4; i++) begin rf[i] = 10'd0; arch[i] = 10'd0; end

    // Reset held with EXECUTE high: nothing may start
    repeat (3) begin
      @(posedge CLKb); #1;
      chk("reset", 64'(obs_ctl()), 64'd0);
    end
    @(negedge CLKb);
    RSTb = 1'b1;

    // LOAD R2 <- 0x155, accepted on the first edge after reset release
    issue(10'h200, 10'h155, 1'b0, 1'b0);
    chk("load_r2", 64'(rf[2]), 64'h155);
    idle_chk(1);

    // ADD R1,R3 with R1=0x3FF, R3=0x002 wraps to 0x001
    issue(10'h100, 10'h3FF, 1'b0, 1'b0);
    issue(10'h300, 10'h002, 1'b0, 1'b0);
    issue(10'h1C2, 10'h000, 1'b0, 1'b0);
    chk("add_wrap", 64'(rf[1]), 64'h001);
    idle_chk(1);

    // Back-to-back SUB R0,R0 then COPY R3<-R0, EXECUTE held high throughout
    issue(10'h003, 10'h000, 1'b1, 1'b1);
    issue(10'h301, 10'h000, 1'b0, 1'b0);
    chk("sub_self", 64'(rf[0]), 64'h000);
    chk("copy_r3", 64'(rf[3]), 64'h000);
    idle_chk(1);

    // AND R2,R1 with a stray request raised while busy: one DONE, one write
    d0 = done_cnt; w0 = enw_cnt;
    issue(10'h245, 10'h0AA, 1'b1, 1'b0);
    idle_chk(2);
    chk("and_one_done", 64'(done_cnt - d0), 64'd1);
    chk("and_one_write", 64'(enw_cnt - w0), 64'd1);

    // NOP (opcode 1010) with reserved bits set
    d0 = done_cnt; w0 = enw_cnt;
    issue(10'h03A, 10'h111, 1'b0, 1'b0);
    idle_chk(1);
    chk("nop_done", 64'(done_cnt - d0), 64'd1);
    chk("nop_no_write", 64'(enw_cnt - w0), 64'd0);

    // Reset in T1 of an ADD: abandoned, no write, no DONE
    d0 = done_cnt; w0 = enw_cnt;
    snap = {rf[3], rf[2], rf[1], rf[0]};
    cif.INSTR = 10'h1C2;
    cif.EXECUTE = 1'b1;
    @(posedge CLKb); #1;
    cif.EXECUTE = 1'b0;
    chk("rst_t1", 64'(obs_ctl()), 64'(exp_ctrl(10'h1C2, 1)));
    RSTb = 1'b0;
    #1;
    chk("rst_async", 64'(obs_ctl()), 64'd0);
    @(negedge CLKb); #1;
    RSTb = 1'b1;
    idle_chk(2);
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_no_write", 64'(enw_cnt - w0), 64'd0);
    chk("rst_regs", {24'd0, rf[3], rf[2], rf[1], rf[0]}, {24'd0, snap});

    // Random instruction stream with random gaps, chaining and stray requests
    for (int i = 0; i < 60; i++) begin
      bit ch;
      ch = (i < 59) && ($urandom_range(0, 1) == 1);
      issue(10'($urandom), 10'($urandom), ($urandom_range(0, 3) == 0), ch);
      if (!ch) idle_chk(1);
    end

    chk("total_done", 64'(done_cnt), 64'(exp_done));
    chk("total_writes", 64'(enw_cnt), 64'(exp_enw));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
